hit_judge: RTL and testbench

//  Consumes the lowest active falling note (lane mask + vertical position) from the note-pattern stage
//  and judges the player's four lane buttons against it; accumulates score and combo.

---
 rtl/hit_judge_pkg.sv | 36 +++
 rtl/hit_judge_if.sv | 24 ++
 rtl/hit_judge_lane_debounce.sv | 45 ++++
 rtl/hit_judge.sv | 152 +++++++++++++++
 tb/tb_hit_judge.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hit_judge_pkg.sv
// Shared types and constants for the rhythm-game hit judge: FSM states, lane indices,
// score/combo widths and the combo-to-multiplier mapping.
package hit_judge_pkg;

   localparam int unsigned LANES      = 4;
   localparam int unsigned LANE_RED   = 0;
   localparam int unsigned LANE_GREEN = 1;
   localparam int unsigned LANE_BLUE  = 2;
   localparam int unsigned LANE_YEL   = 3;

   localparam int unsigned Y_W     = 8;
   localparam int unsigned CMP_W   = 9;
   localparam int unsigned SCORE_W = 16;
   localparam int unsigned COMBO_W = 8;

   localparam logic [SCORE_W-1:0] SCORE_MAX = 16'hFFFF;
   localparam logic [COMBO_W-1:0] COMBO_MAX = 8'hFF;

   typedef logic [LANES-1:0] lane_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_TRACK,
      ST_COLLECT,
      ST_RESOLVE,
      ST_COOLDOWN
   } state_t;

   // Shift amount applied to the base points, taken from the combo before it increments.
   function automatic logic [1:0] combo_mult(input logic [COMBO_W-1:0] combo);
      if (combo >= COMBO_W'(16))     return 2'd2;
      else if (combo >= COMBO_W'(8)) return 2'd1;
      else                           return 2'd0;
   endfunction

endpackage

// File: rtl/hit_judge_if.sv
// Note/judgement bus between the note-pattern stage (master) and the hit judge (slave).
interface hit_judge_if;
   import hit_judge_pkg::*;

   logic                 note_valid;
   lane_t                lane_mask;
   logic [Y_W-1:0]       note_y;
   logic                 note_consume;
   logic                 hit_pulse;
   logic                 miss_pulse;
   logic [SCORE_W-1:0]   score;
   logic [COMBO_W-1:0]   combo;

   modport master (
      output note_valid, lane_mask, note_y,
      input  note_consume, hit_pulse, miss_pulse, score, combo
   );

   modport slave (
      input  note_valid, lane_mask, note_y,
      output note_consume, hit_pulse, miss_pulse, score, combo
   );

endinterface

// File: rtl/hit_judge_lane_debounce.sv
// One lane of button conditioning: 2-flop synchroniser, stability counter, and a
// one-cycle press pulse on each accepted release-to-press transition.
module lane_debounce #(
   parameter int unsigned DEBOUNCE_CYC = 240000
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic press
);

   localparam int unsigned CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

   logic [1:0]       sync;
   logic [CNT_W-1:0] cnt;
   logic             db;
   logic             db_d;

   // The counter only runs while the synchronised input disagrees with the accepted state.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync  <= 2'b00;
         cnt   <= '0;
         db    <= 1'b0;
         db_d  <= 1'b0;
         press <= 1'b0;
      end else begin
         sync  <= {sync[0], raw};
         db_d  <= db;
         press <= db & ~db_d;
         if (sync[1] != db) begin
            if (cnt == CNT_LAST) begin
               db  <= sync[1];
               cnt <= '0;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/hit_judge.sv
// Judges debounced lane presses against the lowest falling note and keeps score and combo.
module hit_judge
   import hit_judge_pkg::*;
#(
   parameter int unsigned HIT_Y        = 200,
   parameter int unsigned HIT_WIN      = 8,
   parameter int unsigned DEBOUNCE_CYC = 240000,
   parameter int unsigned CHORD_CYC    = 120000,
   parameter int unsigned PTS_HIT      = 10
) (
   input  logic             CLOCK_24,
   input  logic             reset,
   input  lane_t            buttons,
   hit_judge_if.slave       bus
);

   localparam int unsigned WIN_LO = (HIT_Y >= HIT_WIN) ? (HIT_Y - HIT_WIN) : 0;
   localparam int unsigned WIN_HI = HIT_Y + HIT_WIN;
   localparam int unsigned TMR_W  = (CHORD_CYC > 1) ? $clog2(CHORD_CYC + 1) : 1;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CHORD_CYC - 1);
   localparam logic [CMP_W-1:0] LO9 = CMP_W'(WIN_LO);
   localparam logic [CMP_W-1:0] HI9 = CMP_W'(WIN_HI);

   lane_t press;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      lane_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
         .clk   (CLOCK_24),
         .reset (reset),
         .raw   (buttons[i]),
         .press (press[i])
      );
   end

   state_t             state, state_n;
   lane_t              acc, acc_n;
   logic [TMR_W-1:0]   timer, timer_n;
   logic [SCORE_W-1:0] score_q, score_n;
   logic [COMBO_W-1:0] combo_q, combo_n;
   logic               consume_q, consume_n;
   logic               hit_q, hit_n;
   logic               miss_q, miss_n;
   logic               judge, judge_hit;

   logic [CMP_W-1:0]   y9;
   logic               late, below, in_win;
   logic [SCORE_W:0]   add_pts, sum_pts;

   assign y9     = CMP_W'(bus.note_y);
   assign late   = y9 > HI9;
   assign below  = y9 < LO9;
   assign in_win = bus.note_valid & ~late & ~below;

   assign add_pts = (SCORE_W+1)'(PTS_HIT) << combo_mult(combo_q);
   assign sum_pts = {1'b0, score_q} + add_pts;

   always_ff @(posedge CLOCK_24) begin
      if (reset) begin
         state     <= ST_IDLE;
         acc       <= '0;
         timer     <= '0;
         score_q   <= '0;
         combo_q   <= '0;
         consume_q <= 1'b0;
         hit_q     <= 1'b0;
         miss_q    <= 1'b0;
      end else begin
         state     <= state_n;
         acc       <= acc_n;
         timer     <= timer_n;
         score_q   <= score_n;
         combo_q   <= combo_n;
         consume_q <= consume_n;
         hit_q     <= hit_n;
         miss_q    <= miss_n;
      end
   end

   // Judgement is decided on the edge into RESOLVE so pulses and score land during RESOLVE.
   always_comb begin
      state_n   = state;
      acc_n     = acc;
      timer_n   = timer;
      score_n   = score_q;
      combo_n   = combo_q;
      consume_n = 1'b0;
      hit_n     = 1'b0;
      miss_n    = 1'b0;
      judge     = 1'b0;
      judge_hit = 1'b0;

      unique case (state)
         ST_IDLE: begin
            if (bus.note_valid) state_n = ST_TRACK;
         end
         ST_TRACK: begin
            if (!bus.note_valid) begin
               state_n = ST_IDLE;
            end else if (late) begin
               state_n = ST_RESOLVE;
               judge   = 1'b1;
            end else if (|press) begin
               state_n = ST_COLLECT;
               acc_n   = press;
               timer_n = TMR_LAST;
            end
         end
         ST_COLLECT: begin
            if (!bus.note_valid) begin
               state_n = ST_IDLE;
               acc_n   = '0;
            end else if (timer == '0) begin
               state_n   = ST_RESOLVE;
               judge     = 1'b1;
               judge_hit = in_win && ((acc | press) == bus.lane_mask);
               acc_n     = '0;
            end else begin
               acc_n   = acc | press;
               timer_n = timer - TMR_W'(1);
            end
         end
         ST_RESOLVE: begin
            state_n = ST_COOLDOWN;
         end
         ST_COOLDOWN: begin
            if (!bus.note_valid || below) state_n = ST_IDLE;
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase

      if (judge) begin
         consume_n = 1'b1;
         if (judge_hit) begin
            hit_n   = 1'b1;
            score_n = sum_pts[SCORE_W] ? SCORE_MAX : sum_pts[SCORE_W-1:0];
            combo_n = (combo_q == COMBO_MAX) ? COMBO_MAX : combo_q + COMBO_W'(1);
         end else begin
            miss_n  = 1'b1;
            combo_n = '0;
         end
      end
   end

   assign bus.note_consume = consume_q;
   assign bus.hit_pulse    = hit_q;
   assign bus.miss_pulse   = miss_q;
   assign bus.score        = score_q;
   assign bus.combo        = combo_q;

endmodule

// File: tb/tb_hit_judge.sv
// Scoreboard bench for hit_judge: scenario tasks push expected judgements, a monitor pops them.
module tb_hit_judge;
   import hit_judge_pkg::*;

   logic  clk;
   logic  reset;
   lane_t buttons;

   hit_judge_if bus();

   hit_judge #(
      .HIT_Y(200), .HIT_WIN(8), .DEBOUNCE_CYC(4), .CHORD_CYC(3), .PTS_HIT(10)
   ) dut (
      .CLOCK_24 (clk),
      .reset    (reset),
      .buttons  (buttons),
      .bus      (bus.slave)
   );

   typedef struct packed {
      logic        hit;
      logic [15:0] score;
      logic [7:0]  combo;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   int          total;
   int          bad;
   int          judge_cnt;
   logic [7:0]  pulse_y;
   logic        prev_pulse;
   int unsigned exp_score;
   int unsigned exp_combo;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Reference scoring model; the result is queued for the monitor.
   task automatic push_exp(input bit hit);
      int unsigned m;
      exp_t e;
      if (hit) begin
         m = (exp_combo >= 16) ? 2 : (exp_combo >= 8) ? 1 : 0;
         exp_score = exp_score + (10 << m);
         if (exp_score > 65535) exp_score = 65535;
         if (exp_combo < 255) exp_combo = exp_combo + 1;
      end else begin
         exp_combo = 0;
      end
      e.hit   = hit;
      e.score = 16'(exp_score);
      e.combo = 8'(exp_combo);
      exp_q.push_back(e);
   endtask

   task automatic wait_judge(input int target, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (judge_cnt >= target) begin
            ok = 1'b1;
            break;
         end
         cyc(1);
      end
   endtask

   task automatic next_note(input lane_t m, input logic [7:0] y);
      bus.note_valid = 1'b0;
      cyc(2);
      bus.lane_mask  = m;
      bus.note_y     = y;
      bus.note_valid = 1'b1;
      cyc(2);
   endtask

   task automatic do_reset();
      reset   = 1'b1;
      buttons = '0;
      cyc(2);
      reset     = 1'b0;
      exp_score = 0;
      exp_combo = 0;
      exp_q.delete();
      cyc(1);
   endtask

   task automatic do_hit(input string name);
      bit ok;
      next_note(4'b0001, 8'd198);
      push_exp(1'b1);
      buttons = 4'b0001;
      wait_judge(judge_cnt + 1, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL %s timeout got no judgement required one", name); end
      buttons = '0;
      cyc(9);
   endtask

   task automatic test_reset();
      bus.note_valid = 1'b0;
      bus.lane_mask  = '0;
      bus.note_y     = '0;
      reset   = 1'b1;
      buttons = '0;
      cyc(3);
      total++;
      if ({bus.note_consume, bus.hit_pulse, bus.miss_pulse} !== 3'b000 || bus.score !== 16'd0 || bus.combo !== 8'd0) begin
         bad++;
         $display("FAIL reset_hold pulses=%b score=%0d combo=%0d required all 0",
                  {bus.note_consume, bus.hit_pulse, bus.miss_pulse}, bus.score, bus.combo);
      end
      reset = 1'b0;
      exp_score = 0;
      exp_combo = 0;
      cyc(3);
      total++;
      if (bus.note_consume !== 1'b0 || bus.score !== 16'd0 || bus.combo !== 8'd0) begin
         bad++;
         $display("FAIL reset_release consume=%b score=%0d combo=%0d required 0", bus.note_consume, bus.score, bus.combo);
      end
   endtask

   task automatic test_single_hit();
      do_hit("single_hit");
      total++;
      if (bus.score !== 16'd10 || bus.combo !== 8'd1) begin
         bad++;
         $display("FAIL single_hit_score score=%0d combo=%0d required 10 1", bus.score, bus.combo);
      end
   endtask

   task automatic test_chord();
      bit ok;
      next_note(4'b0110, 8'd198);
      push_exp(1'b1);
      buttons = 4'b0010;
      cyc(1);
      buttons = 4'b0110;
      wait_judge(judge_cnt + 1, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL chord_hit timeout got no judgement required one"); end
      buttons = '0;
      cyc(9);
      next_note(4'b0110, 8'd198);
      push_exp(1'b0);
      buttons = 4'b0010;
      wait_judge(judge_cnt + 1, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL chord_partial timeout got no judgement required one"); end
      buttons = '0;
      cyc(9);
      total++;
      if (bus.combo !== 8'd0 || bus.score !== 16'd20) begin
         bad++;
         $display("FAIL chord_partial_state score=%0d combo=%0d required 20 0", bus.score, bus.combo);
      end
   endtask

   task automatic test_late_miss();
      bit ok;
      int jc;
      next_note(4'b1000, 8'd200);
      jc = judge_cnt;
      for (int y = 201; y <= 208; y++) begin
         bus.note_y = 8'(y);
         cyc(1);
      end
      total++;
      if (judge_cnt !== jc) begin bad++; $display("FAIL late_early_judge count=%0d required %0d", judge_cnt, jc); end
      push_exp(1'b0);
      bus.note_y = 8'd209;
      wait_judge(jc + 1, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL late_miss timeout got no judgement required one"); end
      total++;
      if (pulse_y !== 8'd209) begin bad++; $display("FAIL late_miss_y y=%0d required 209", pulse_y); end
   endtask

   task automatic test_early_cooldown();
      bit ok;
      int jc;
      next_note(4'b0001, 8'd150);
      push_exp(1'b0);
      buttons = 4'b0001;
      wait_judge(judge_cnt + 1, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL early_miss timeout got no judgement required one"); end
      bus.note_y = 8'd195;
      buttons = '0;
      cyc(10);
      jc = judge_cnt;
      buttons = 4'b0001;
      cyc(15);
      buttons = '0;
      cyc(10);
      total++;
      if (judge_cnt !== jc) begin bad++; $display("FAIL cooldown_hold count=%0d required %0d", judge_cnt, jc); end
      bus.note_y = 8'd191;
      cyc(2);
      bus.note_y = 8'd198;
      push_exp(1'b1);
      buttons = 4'b0001;
      wait_judge(jc + 1, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL cooldown_exit timeout got no judgement required one"); end
      buttons = '0;
      cyc(9);
   endtask

   task automatic test_bounce();
      int jc;
      next_note(4'b0001, 8'd198);
      jc = judge_cnt;
      for (int i = 0; i < 10; i++) begin
         buttons[LANE_RED] = ~buttons[LANE_RED];
         cyc(2);
      end
      cyc(12);
      total++;
      if (judge_cnt !== jc) begin bad++; $display("FAIL bounce count=%0d required %0d", judge_cnt, jc); end
   endtask

   task automatic test_multiplier();
      do_reset();
      for (int i = 0; i < 20; i++) do_hit("mult_hit");
      total++;
      if (bus.score !== 16'd400 || bus.combo !== 8'd20) begin
         bad++;
         $display("FAIL mult_20 score=%0d combo=%0d required 400 20", bus.score, bus.combo);
      end
      for (int i = 0; i < 236; i++) do_hit("sat_hit");
      total++;
      if (bus.score !== 16'd9840 || bus.combo !== 8'd255) begin
         bad++;
         $display("FAIL combo_sat score=%0d combo=%0d required 9840 255", bus.score, bus.combo);
      end
   endtask

   task automatic test_reset_collect();
      int jc;
      next_note(4'b0011, 8'd198);
      jc = judge_cnt;
      buttons = 4'b0001;
      repeat (8) @(posedge clk);
      #1;
      reset   = 1'b1;
      buttons = '0;
      cyc(1);
      total++;
      if ({bus.note_consume, bus.hit_pulse, bus.miss_pulse} !== 3'b000 || bus.score !== 16'd0 || bus.combo !== 8'd0) begin
         bad++;
         $display("FAIL reset_collect pulses=%b score=%0d combo=%0d required all 0",
                  {bus.note_consume, bus.hit_pulse, bus.miss_pulse}, bus.score, bus.combo);
      end
      reset = 1'b0;
      exp_score = 0;
      exp_combo = 0;
      cyc(20);
      total++;
      if (judge_cnt !== jc || bus.score !== 16'd0) begin
         bad++;
         $display("FAIL reset_collect_after count=%0d score=%0d required %0d 0", judge_cnt, bus.score, jc);
      end
   endtask

   initial begin
      total      = 0;
      bad        = 0;
      judge_cnt  = 0;
      pulse_y    = '0;
      prev_pulse = 1'b0;
      exp_score  = 0;
      exp_combo  = 0;
      reset      = 1'b1;
      buttons    = '0;
      bus.note_valid = 1'b0;
      bus.lane_mask  = '0;
      bus.note_y     = '0;

      fork
         forever begin
            @(negedge clk);
            if (reset) begin
               prev_pulse = 1'b0;
            end else begin
               if (bus.note_consume) begin
                  judge_cnt++;
                  pulse_y = bus.note_y;
                  total++;
                  if (exp_q.size() == 0) begin
                     bad++;
                     $display("FAIL judge_unexpected hit=%b miss=%b score=%0d required no judgement",
                              bus.hit_pulse, bus.miss_pulse, bus.score);
                  end else begin
                     mon_e = exp_q.pop_front();
                     if (bus.hit_pulse !== mon_e.hit || bus.miss_pulse !== !mon_e.hit ||
                         bus.score !== mon_e.score || bus.combo !== mon_e.combo) begin
                        bad++;
                        $display("FAIL judge hit=%b miss=%b score=%0d combo=%0d required hit=%b score=%0d combo=%0d",
                                 bus.hit_pulse, bus.miss_pulse, bus.score, bus.combo,
                                 mon_e.hit, mon_e.score, mon_e.combo);
                     end
                  end
               end
               if (bus.note_consume || bus.hit_pulse || bus.miss_pulse) begin
                  total++;
                  if (prev_pulse || !bus.note_consume || (bus.hit_pulse == bus.miss_pulse)) begin
                     bad++;
                     $display("FAIL pulse_shape consume=%b hit=%b miss=%b prev=%b required one-hot single cycle",
                              bus.note_consume, bus.hit_pulse, bus.miss_pulse, prev_pulse);
                  end
               end
               prev_pulse = bus.note_consume;
            end
         end
      join_none

      test_reset();
      test_single_hit();
      test_chord();
      test_late_miss();
      test_early_cooldown();
      test_bounce();
      test_multiplier();
      test_reset_collect();

      total++;
      if (exp_q.size() != 0) begin bad++; $display("FAIL leftover_expect count=%0d required 0", exp_q.size()); end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
